// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register front end.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      ST_CMD = 2'd0,
      ST_WR  = 2'd1,
      ST_RD  = 2'd2
   } state_e;

   localparam int RW_BIT = 7;
   localparam int BYTE_W = 8;

endpackage

// File: rtl/spi_reg_bank.sv
// 2**ADDR_W x 8 register bank: reg 0 is the read-only ID constant, others writable.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int          ADDR_W   = 4,
   parameter logic [7:0]  ID_VALUE = 8'hA5
) (
   input  logic                                w_SPI_Clk,
   input  logic                                i_Rst_L,
   input  logic                                we_i,
   input  logic [ADDR_W-1:0]                   waddr_i,
   input  logic [BYTE_W-1:0]                   wdata_i,
   input  logic [ADDR_W-1:0]                   raddr_i,
   output logic [BYTE_W-1:0]                   rdata_o,
   output logic [BYTE_W*(2**ADDR_W)-1:0]       regs_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][BYTE_W-1:0] all_regs;

   assign all_regs[0] = ID_VALUE;

   // No storage for reg 0, so writes to it vanish here without extra gating.
   for (genvar g = 1; g < DEPTH; g++) begin : g_reg
      logic [BYTE_W-1:0] reg_q;
      always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
         if (!i_Rst_L)                              reg_q <= '0;
         else if (we_i && waddr_i == ADDR_W'(g))    reg_q <= wdata_i;
      end
      assign all_regs[g] = reg_q;
   end

   assign rdata_o = all_regs[raddr_i];
   assign regs_o  = all_regs;

endmodule

// File: rtl/spi_reg_frontend.sv
// SPI-clock-domain command decoder and register front end with toggle write handshake.
// Optional burst addressing via SPI_REG_FRONTEND_AUTOINC_EN.
module spi_reg_frontend
   import spi_reg_pkg::*;
#(
   parameter int          ADDR_W   = 4,
   parameter logic [7:0]  ID_VALUE = 8'hA5
) (
   input  logic                                i_Rst_L,
   input  logic                                w_SPI_Clk,
   input  logic                                i_SPI_CS_n,
   input  logic                                i_SPI_PICO,
   output logic                                o_POCI_Bit,
   output logic                                o_Wr_Tgl,
   output logic [ADDR_W-1:0]                   o_Wr_Addr,
   output logic [BYTE_W-1:0]                   o_Wr_Data,
   output logic [BYTE_W*(2**ADDR_W)-1:0]       o_Regs
);

   state_e               state_q, state_d;
   logic [2:0]           bit_cnt_q;
   logic [BYTE_W-2:0]    shift_q;
   logic [BYTE_W-2:0]    rd_sh_q;
   logic                 poci_q;
   logic [ADDR_W-1:0]    addr_q;
   logic                 wr_tgl_q;
   logic [ADDR_W-1:0]    wr_addr_q;
   logic [BYTE_W-1:0]    wr_data_q;

   logic                 frame_rst_n;
   logic                 byte_done;
   logic [BYTE_W-1:0]    rx_byte;
   logic [ADDR_W-1:0]    cmd_addr;
   logic [ADDR_W-1:0]    addr_step;
   logic [ADDR_W-1:0]    raddr;
   logic [BYTE_W-1:0]    rdata;
   logic                 bank_we;
   logic                 rd_load;
   logic                 addr_ld;
   logic                 addr_adv;

   // Frame state clears on reset or CS_n high; bank and o_Wr_* survive CS_n.
   assign frame_rst_n = i_Rst_L & ~i_SPI_CS_n;
   assign byte_done   = (bit_cnt_q == 3'd7);
   assign rx_byte     = {shift_q, i_SPI_PICO};
   assign cmd_addr    = rx_byte[ADDR_W-1:0];

`ifdef SPI_REG_FRONTEND_AUTOINC_EN
   assign addr_step = addr_q + ADDR_W'(1);
`else
   assign addr_step = addr_q;
`endif

   always_ff @(posedge w_SPI_Clk or negedge frame_rst_n) begin
      if (!frame_rst_n) state_q <= ST_CMD;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CMD:  if (byte_done) state_d = rx_byte[RW_BIT] ? ST_RD : ST_WR;
         ST_WR,
         ST_RD:   state_d = state_q;
         default: state_d = ST_CMD;
      endcase
   end

   always_comb begin
      bank_we  = 1'b0;
      rd_load  = 1'b0;
      addr_ld  = 1'b0;
      addr_adv = 1'b0;
      raddr    = addr_step;
      case (state_q)
         ST_CMD: begin
            raddr   = cmd_addr;
            addr_ld = byte_done;
            rd_load = byte_done & rx_byte[RW_BIT];
         end
         ST_WR: begin
            bank_we  = byte_done & (addr_q != '0);
            addr_adv = byte_done;
         end
         ST_RD: begin
            rd_load  = byte_done;
            addr_adv = byte_done;
         end
         default: ;
      endcase
   end

   always_ff @(posedge w_SPI_Clk or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rd_sh_q   <= '0;
         poci_q    <= 1'b0;
         addr_q    <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_q + 3'd1;
         shift_q   <= rx_byte[BYTE_W-2:0];
         if (addr_ld)       addr_q <= cmd_addr;
         else if (addr_adv) addr_q <= addr_step;
         // Bit 7 goes straight to the pin; the rest waits in rd_sh_q.
         if (rd_load) begin
            poci_q  <= rdata[BYTE_W-1];
            rd_sh_q <= rdata[BYTE_W-2:0];
         end else if (state_q == ST_RD) begin
            poci_q  <= rd_sh_q[BYTE_W-2];
            rd_sh_q <= {rd_sh_q[BYTE_W-3:0], 1'b0};
         end else begin
            poci_q  <= 1'b0;
            rd_sh_q <= '0;
         end
      end
   end

   always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_tgl_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else if (bank_we) begin
         wr_tgl_q  <= ~wr_tgl_q;
         wr_addr_q <= addr_q;
         wr_data_q <= rx_byte;
      end
   end

   spi_reg_bank #(
      .ADDR_W   (ADDR_W),
      .ID_VALUE (ID_VALUE)
   ) u_bank (
      .w_SPI_Clk (w_SPI_Clk),
      .i_Rst_L   (i_Rst_L),
      .we_i      (bank_we),
      .waddr_i   (addr_q),
      .wdata_i   (rx_byte),
      .raddr_i   (raddr),
      .rdata_o   (rdata),
      .regs_o    (o_Regs)
   );

   assign o_POCI_Bit = poci_q;
   assign o_Wr_Tgl   = wr_tgl_q;
   assign o_Wr_Addr  = wr_addr_q;
   assign o_Wr_Data  = wr_data_q;

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Directed bench for spi_reg_frontend: byte-level register model plus literal expectations.
module tb_spi_reg_frontend;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         cs_n  = 1'b1;
   logic         pico  = 1'b0;
   logic         poci;
   logic         tgl;
   logic [3:0]   wa;
   logic [7:0]   wd;
   logic [127:0] regs;

   always #5 clk = ~clk;

   spi_reg_frontend #(.ADDR_W(ADDR_W), .ID_VALUE(8'hA5)) dut (
      .i_Rst_L    (rst_n),
      .w_SPI_Clk  (clk),
      .i_SPI_CS_n (cs_n),
      .i_SPI_PICO (pico),
      .o_POCI_Bit (poci),
      .o_Wr_Tgl   (tgl),
      .o_Wr_Addr  (wa),
      .o_Wr_Data  (wd),
      .o_Regs     (regs)
   );

   logic [7:0] m_regs [DEPTH];
   int         m_tgl_cnt = 0;
   logic [3:0] m_wa      = '0;
   logic [7:0] m_wd      = '0;
   logic       m_poci    = 1'b0;
   int         checks    = 0;
   int         errors    = 0;
   bit         cmp_en    = 1'b0;
   int         dut_tgl_cnt = 0;
   logic [7:0] rd_bits;

   function automatic logic [7:0] m_rd(input int a);
      return (a == 0) ? 8'hA5 : m_regs[a];
   endfunction

   function automatic int m_step(input int a);
`ifdef SPI_REG_FRONTEND_AUTOINC_EN
      return (a + 1) % DEPTH;
`else
      return a;
`endif
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(tgl) if (rst_n) dut_tgl_cnt++;

   always @(negedge clk) begin : cmp
      logic [127:0] ef;
      if (cmp_en) begin
         for (int i = 0; i < DEPTH; i++) ef[8*i +: 8] = m_rd(i);
         check("regs",    regs, ef);
         check("wr_tgl",  tgl,  m_tgl_cnt[0]);
         check("wr_addr", wa,   m_wa);
         check("wr_data", wd,   m_wd);
         check("poci",    poci, m_poci);
      end
   end

   // Drives one frame of n bytes (or abort_bits edges if nonzero) and advances the model.
   task automatic do_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int abort_bits);
      logic [7:0] by [4];
      int         nbits, addr, k, bi;
      bit         rd;
      logic [7:0] cur;
      by[0] = b0; by[1] = b1; by[2] = b2; by[3] = b3;
      nbits = (abort_bits > 0) ? abort_bits : n * 8;
      rd = 1'b0; addr = 0; cur = '0; rd_bits = '0;
      @(posedge clk); #2 cs_n = 1'b0;
      for (int e = 1; e <= nbits; e++) begin
         bi = (e - 1) / 8;
         k  = (e - 1) % 8;
         @(negedge clk) pico = by[bi][7-k];
         @(posedge clk); #1;
         if (e == 8) begin
            rd   = by[0][7];
            addr = int'(by[0][3:0]);
            cur  = m_rd(addr);
            m_poci = rd ? cur[7] : 1'b0;
         end else if (e > 8) begin
            if (k == 7) begin
               if (!rd && addr != 0) begin
                  m_regs[addr] = by[bi];
                  m_wa = addr[3:0];
                  m_wd = by[bi];
                  m_tgl_cnt++;
               end
               addr = m_step(addr);
               if (rd) begin
                  cur = m_rd(addr);
                  m_poci = cur[7];
               end
            end else if (rd) begin
               m_poci = cur[6-k];
            end
         end
         if (e >= 8 && e <= 15) rd_bits = {rd_bits[6:0], poci};
      end
      #1 cs_n = 1'b1;
      m_poci = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_regs", regs, {120'h0, 8'hA5});
      check("rst_tgl",  tgl,  1'b0);
      check("rst_poci", poci, 1'b0);
      check("rst_wa",   wa,   4'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      cmp_en = 1'b1;

      do_frame(2, 8'h03, 8'h5C, 8'h00, 8'h00, 0);
      check("wr1_reg3", regs[31:24], 8'h5C);
      check("wr1_addr", wa, 4'h3);
      check("wr1_data", wd, 8'h5C);
      check("wr1_tgls", dut_tgl_cnt, 1);

      do_frame(2, 8'h83, 8'h00, 8'h00, 8'h00, 0);
      check("rd1_bits", rd_bits, 8'b0101_1100);

      do_frame(2, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
      check("id_ro",    regs[7:0], 8'hA5);
      check("id_tgls",  dut_tgl_cnt, 1);
      do_frame(2, 8'h80, 8'h00, 8'h00, 8'h00, 0);
      check("id_bits",  rd_bits, 8'hA5);

      do_frame(4, 8'h0F, 8'h11, 8'h22, 8'h33, 0);
`ifdef SPI_REG_FRONTEND_AUTOINC_EN
      check("burst_r15",  regs[127:120], 8'h11);
      check("burst_r1",   regs[15:8],    8'h33);
      check("burst_tgls", dut_tgl_cnt,   3);
`else
      check("burst_r15",  regs[127:120], 8'h33);
      check("burst_r1",   regs[15:8],    8'h00);
      check("burst_tgls", dut_tgl_cnt,   4);
`endif
      check("burst_r0", regs[7:0], 8'hA5);

      do_frame(2, 8'h02, 8'hAB, 8'h00, 8'h00, 13);
      check("abort_r2",   regs[23:16], 8'h00);
      check("abort_tgls", dut_tgl_cnt, m_tgl_cnt);
      do_frame(2, 8'h82, 8'h00, 8'h00, 8'h00, 0);
      check("abort_next", rd_bits, 8'h00);

      do_frame(2, 8'h83, 8'h00, 8'h00, 8'h00, 11);
      do_frame(3, 8'h8F, 8'h00, 8'h00, 8'h00, 0);
      do_frame(2, 8'h83, 8'h00, 8'h00, 8'h00, 0);
      check("rd3_again", rd_bits, 8'h5C);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_frontend.md
# spi_reg_frontend

SPI-clock-domain register front end that consumes the PICO bit stream on the same sampling edge the SPI peripheral uses and produces POCI read data for the SPI pins. It decodes a command byte (R/W + address), then writes or reads a small 8-bit register bank with optional address auto-increment. Write events leave the block on a toggle handshake so the system-clock side can synchronise them without SPI clock activity.

## Interface
- ADDR_W, 4: register address width; bank depth 2**ADDR_W; legal range 1..7.
- ID_VALUE, 8'hA5: constant returned by read-only register 0.
- i_Rst_L  input  1  asynchronous, active-low reset.
- w_SPI_Clk  input  1  mode-adjusted SPI clock; all logic on its rising edge (sampling edge).
- i_SPI_CS_n  input  1  chip select, active low; high is an asynchronous frame clear.
- i_SPI_PICO  input  1  serial data in, MSB first.
- o_POCI_Bit  output  1  serial read data, updated on w_SPI_Clk rising edge.
- o_Wr_Tgl  output  1  inverts once per committed write.
- o_Wr_Addr  output  ADDR_W  address of last committed write, held until the next write.
- o_Wr_Data  output  8  data of last committed write, held until the next write.
- o_Regs  output  8*2**ADDR_W  flattened bank, reg n at [8n+7:8n]; reg 0 reads ID_VALUE.

## Operation
- Frame = CS_n low interval. Byte 0 = command {RW, A[6:0]}: RW=1 read, RW=0 write; address = A[ADDR_W-1:0], upper bits ignored.
- FSM states: CMD, WR, RD. Bit counter 3 bits, counts edges within the current byte, wraps 7->0.
- CMD: shift PICO into the shift register. On the 8th edge: latch address, go to RD or WR. If RD, load the read shift register with reg[addr] and drive its bit 7 on o_POCI_Bit on that same edge.
- WR: shift PICO. On each byte-completing edge (edge 16, 24, ...), if addr != 0: reg[addr] <= byte, o_Wr_Addr <= addr, o_Wr_Data <= byte, o_Wr_Tgl inverts. If addr == 0: write dropped, o_Wr_* unchanged. Then apply the address step.
- RD: each edge drives the next lower bit. On the byte-completing edge, apply the address step, reload from the new address and drive its bit 7.
- Address step: addr <= addr + 1 modulo 2**ADDR_W (wraps to 0, which reads ID_VALUE), or no change; see Configuration.
- o_POCI_Bit = 0 in CMD and WR states.
- CS_n high (asynchronous): FSM -> CMD, bit counter 0, shift registers 0, o_POCI_Bit 0. A partially shifted byte is discarded. Register bank and o_Wr_* are not affected.
- i_Rst_L low (asynchronous): everything cleared, including bank regs 1..N-1 = 8'h00, o_Wr_Tgl=0, o_Wr_Addr=0, o_Wr_Data=0, o_POCI_Bit=0. o_Regs reset value = {0..., ID_VALUE}.
- Simultaneous reset and CS_n high: reset dominates.

## Timing
- Edge n = nth w_SPI_Clk rising edge after the CS_n fall.
- Command latched at edge 8. Read bit 7 valid after edge 8, bit k valid after edge 15-k. The next read byte's bit 7 is valid after edge 16.
- Write commit, o_Regs update and o_Wr_Tgl change happen at edge 16 + 8m, with 0 latency past the final data bit.
- o_Wr_Addr and o_Wr_Data are stable before o_Wr_Tgl changes and stay stable until the next toggle. The consumer double-registers o_Wr_Tgl and samples the data on a toggle edge.
- Minimum spacing between writes is 8 SPI clocks; the consumer clock must be at least 4x the SPI clock.

## Configuration
- SPI_REG_FRONTEND_AUTOINC_EN defined: the address step is +1 modulo 2**ADDR_W after every data byte, read or write (burst).
- Not defined: the address stays fixed for the whole frame. Repeated writes target one register; repeated reads return the same register.

## Structure
- Package spi_reg_pkg: FSM state enum (CMD, WR, RD), RW bit position constant (7), byte width constant (8).
- One sub-module, spi_reg_bank: the 2**ADDR_W x 8 bank with read-only reg 0, write port, combinational read port and flattened o_Regs.
- The FSM, bit counter and shift registers live in the top module.

## Test plan
- Reset: hold i_Rst_L low -> o_Regs = {0...,8'hA5}, o_Wr_Tgl=0, o_POCI_Bit=0.
- Write single: frame 8'h03, 8'h5C -> reg3=8'h5C at edge 16; o_Wr_Addr=3, o_Wr_Data=8'h5C; o_Wr_Tgl 0->1.
- Read single: frame 8'h83 + 8 dummy clocks -> o_POCI_Bit sequence 0,1,0,1,1,1,0,0 after edges 8..15.
- Burst wrap (AUTOINC_EN): frame 8'h0F, 8'h11, 8'h22, 8'h33 -> reg15=8'h11; reg0 write dropped; reg1=8'h33; o_Wr_Tgl toggles twice. Without the macro: reg15 ends at 8'h33 and o_Wr_Tgl toggles 3 times.
- Abort: raise CS_n after 5 data bits of a write to reg2 -> reg2 unchanged, no toggle, next frame decodes its command normally.
- ID read and read-only: frame 8'h00, 8'hFF -> reg0 stays 8'hA5. Frame 8'h80 -> 8'hA5 shifted out.
